// File: rtl/mem_data_arb.sv
// mem_data_arb: round-robin arbiter and sequencer for the data side of the unified memory.
//
// Two requesters (0 = core load/store unit, 1 = host loader/debug port) each issue single
// 32-bit accesses. A winner is latched into a command register in IDLE. The memory port is
// driven for exactly one BUSY cycle. The response (rdata, err) is registered and presented
// with a one-cycle valid pulse.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   reqN, weN, addrN, wdataN   request, write enable, halfword address [31:1], write data
//   gntN                       access is being performed this cycle (BUSY)
//   validN, rdataN, errN       response pulse, read data, out-of-range flag (data/flag held)
//   busy                       high while the memory port is being driven
//   mem_wr_addr/data/en        memory write port
//   mem_rd_addr, mem_rd_data   memory combinational read port rd1
module mem_data_arb #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [30:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [30:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        valid0,
  output logic        valid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        busy,
  output logic [30:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_en,
  output logic [30:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e state_q, state_d;

  // Requester granted most recently; resets to 1 so requester 0 wins the first tie.
  logic        last_q;

  logic        cmd_id_q;
  logic        cmd_we_q;
  logic [30:0] cmd_addr_q;
  logic [31:0] cmd_wdata_q;
  logic        cmd_ok_q;

  logic        valid0_q, valid1_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        err0_q, err1_q;

  logic        win;
  logic        sel_we;
  logic [30:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_ok;
  logic        cmd_load;
  logic [31:0] rsp_data;

  // Legal iff {addr,0} + 3 < MEM_BYTES. Evaluated in 33 bits so addresses near 2^32 cannot wrap
  // back into range.
  function automatic logic addr_in_range(input logic [30:0] a);
    logic [32:0] last_byte;
    last_byte = {1'b0, a, 1'b0} + 33'd3;
    return last_byte < 33'(MEM_BYTES);
  endfunction

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~last_q;
    end else if (req1) begin
      win = 1'b1;
    end
  end

  always_comb begin
    sel_we    = win ? we1    : we0;
    sel_addr  = win ? addr1  : addr0;
    sel_wdata = win ? wdata1 : wdata0;
    sel_ok    = addr_in_range(sel_addr);
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d  = state_q;
    cmd_load = 1'b0;
    busy     = 1'b0;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d  = StBusy;
          cmd_load = 1'b1;
        end
      end
      StBusy: begin
        busy    = 1'b1;
        gnt0    = ~cmd_id_q;
        gnt1    = cmd_id_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Address/data follow the command register at all times; only the enable is state-gated.
  always_comb begin
    mem_wr_addr = cmd_addr_q;
    mem_rd_addr = cmd_addr_q;
    mem_wr_data = cmd_wdata_q;
    mem_wr_en   = busy & cmd_we_q & cmd_ok_q;
  end

  // Writes and out-of-range reads return zero.
  always_comb begin
    rsp_data = 32'd0;
    if (!cmd_we_q && cmd_ok_q) begin
      rsp_data = mem_rd_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == StBusy) begin
        last_q <= cmd_id_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_id_q    <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= 31'd0;
      cmd_wdata_q <= 32'd0;
      cmd_ok_q    <= 1'b0;
    end else if (cmd_load) begin
      cmd_id_q    <= win;
      cmd_we_q    <= sel_we;
      cmd_addr_q  <= sel_addr;
      cmd_wdata_q <= sel_wdata;
      cmd_ok_q    <= sel_ok;
    end
  end

  // Response registers; only the winner's rdata/err are updated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      if (state_q == StBusy) begin
        if (cmd_id_q) begin
          valid1_q <= 1'b1;
          rdata1_q <= rsp_data;
          err1_q   <= ~cmd_ok_q;
        end else begin
          valid0_q <= 1'b1;
          rdata0_q <= rsp_data;
          err0_q   <= ~cmd_ok_q;
        end
      end
    end
  end

  always_comb begin
    valid0 = valid0_q;
    valid1 = valid1_q;
    rdata0 = rdata0_q;
    rdata1 = rdata1_q;
    err0   = err0_q;
    err1   = err1_q;
  end

endmodule

// File: tb/tb_mem_data_arb.sv
// Self-checking bench for mem_data_arb: byte-array memory model on the DUT memory port,
// independent reference memory for expected read data, and per-requester scoreboards.
module tb_mem_data_arb;

  localparam int unsigned MemBytes = 1024;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [30:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, valid0, valid1, err0, err1, busy;
  logic [31:0] rdata0, rdata1;
  logic [30:0] mem_wr_addr, mem_rd_addr;
  logic [31:0] mem_wr_data, mem_rd_data;
  logic        mem_wr_en;

  int tests = 0;
  int fails = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] mem     [MemBytes];
  logic [7:0] ref_mem [MemBytes];

  logic        pl_en = 1'b0;
  logic [9:0]  pl_ba = 10'd0;
  logic [31:0] pl_data = 32'd0;
  logic [31:0] wba, rba;
  int          wr_cnt = 0;

  always #5 clk = ~clk;

  mem_data_arb #(.MEM_BYTES(MemBytes)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .we0         (we0),
    .addr0       (addr0),
    .wdata0      (wdata0),
    .req1        (req1),
    .we1         (we1),
    .addr1       (addr1),
    .wdata1      (wdata1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .valid0      (valid0),
    .valid1      (valid1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .err0        (err0),
    .err1        (err1),
    .busy        (busy),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
  );

  // Memory model: big-endian, preload port for the bench, write port for the DUT.
  assign wba = {mem_wr_addr, 1'b0};
  assign rba = {mem_rd_addr, 1'b0};

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_ba]         <= pl_data[31:24];
      mem[pl_ba + 10'd1] <= pl_data[23:16];
      mem[pl_ba + 10'd2] <= pl_data[15:8];
      mem[pl_ba + 10'd3] <= pl_data[7:0];
    end else if (mem_wr_en && wba < 32'd1021) begin
      mem[wba[9:0]]         <= mem_wr_data[31:24];
      mem[wba[9:0] + 10'd1] <= mem_wr_data[23:16];
      mem[wba[9:0] + 10'd2] <= mem_wr_data[15:8];
      mem[wba[9:0] + 10'd3] <= mem_wr_data[7:0];
    end
  end

  // Out-of-range reads return a garbage pattern the DUT must not pass through.
  always_comb begin
    mem_rd_data = 32'hA5A5_A5A5;
    if (rba < 32'd1021) begin
      mem_rd_data = {mem[rba[9:0]], mem[rba[9:0] + 10'd1],
                     mem[rba[9:0] + 10'd2], mem[rba[9:0] + 10'd3]};
    end
  end

  always @(negedge clk) begin
    if (mem_wr_en) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on each valid pulse.
  always @(negedge clk) begin
    exp_t e;
    if (gnt0 || gnt1) chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
    if (valid0) begin
      chk("valid0_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("rdata0", rdata0, e.rdata);
        chk("err0", 32'(err0), 32'(e.err));
      end
    end
    if (valid1) begin
      chk("valid1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("rdata1", rdata1, e.rdata);
        chk("err1", 32'(err1), 32'(e.err));
      end
    end
  end

  // Reference model of one access; returns whether the write enable is expected.
  task automatic push_exp(input int id, input logic we, input logic [30:0] a,
                          input logic [31:0] wd, output logic wen);
    longint ba;
    exp_t   e;
    logic   ok;
    ba = longint'({a, 1'b0});
    ok = (ba + 3) < longint'(MemBytes);
    e.err   = ~ok;
    e.rdata = 32'd0;
    if (ok && !we) begin
      e.rdata = {ref_mem[ba], ref_mem[ba + 1], ref_mem[ba + 2], ref_mem[ba + 3]};
    end
    if (ok && we) begin
      ref_mem[ba]     = wd[31:24];
      ref_mem[ba + 1] = wd[23:16];
      ref_mem[ba + 2] = wd[15:8];
      ref_mem[ba + 3] = wd[7:0];
    end
    wen = ok & we;
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  task automatic preload(input logic [9:0] ba, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_ba = ba;
    pl_data = d;
    ref_mem[ba] = d[31:24];
    ref_mem[ba + 10'd1] = d[23:16];
    ref_mem[ba + 10'd2] = d[15:8];
    ref_mem[ba + 10'd3] = d[7:0];
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic access(input int id, input logic we, input logic [30:0] a,
                        input logic [31:0] wd);
    logic got;
    logic wen;
    @(negedge clk);
    if (id == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = (id == 0) ? gnt0 : gnt1;
    end
    chk("gnt_seen", 32'(got), 32'd1);
    if (got) begin
      push_exp(id, we, a, wd, wen);
      chk("busy_at_gnt", 32'(busy), 32'd1);
      chk("mem_rd_addr", 32'(mem_rd_addr), 32'(a));
      chk("mem_wr_en", 32'(mem_wr_en), 32'(wen));
      if (we) chk("mem_wr_data", mem_wr_data, wd);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);  // response checked by the monitor here
    @(negedge clk);
    chk("valid_drops", 32'({valid0, valid1}), 32'd0);
  endtask

  int g_id[4];
  int g_cyc[4];
  int g_n;
  int w0;
  logic wen_unused;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < MemBytes; i++) ref_mem[i] = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("rst_valid", 32'({valid0, valid1}), 32'd0);
    chk("rst_err", 32'({err0, err1}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_wr_data", mem_wr_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    preload(10'h010, 32'h1122_3344);
    preload(10'h3FC, 32'h5566_7788);
    preload(10'h040, 32'h0102_0304);
    preload(10'h024, 32'hA0B0_C0D0);

    // Single read at byte 0x10
    access(0, 1'b0, 31'h8, 32'd0);
    chk("rdata0_held", rdata0, 32'h1122_3344);

    // Write then read via requester 1, byte 0x20
    w0 = wr_cnt;
    access(1, 1'b1, 31'h10, 32'hDEAD_BEEF);
    chk("wr_en_one_cycle", 32'(wr_cnt - w0), 32'd1);
    access(1, 1'b0, 31'h10, 32'd0);
    chk("rdata0_unchanged", rdata0, 32'h1122_3344);
    chk("rdata1_readback", rdata1, 32'hDEAD_BEEF);

    // Halfword-aligned read straddling two words (byte 0x22)
    access(0, 1'b0, 31'h11, 32'd0);

    // Bounds
    w0 = wr_cnt;
    access(0, 1'b0, 31'h1FE, 32'd0);
    access(0, 1'b0, 31'h1FF, 32'd0);
    access(1, 1'b1, 31'h200, 32'h1234_5678);
    access(0, 1'b0, 31'h7FFF_FFFF, 32'd0);
    access(1, 1'b1, 31'h7FFF_FFFF, 32'h1234_5678);
    chk("oob_no_write", 32'(wr_cnt - w0), 32'd0);

    // Contention from reset: grants must alternate 0,1,0,1, two cycles apart
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 31'h8;
    req1 = 1'b1; we1 = 1'b0; addr1 = 31'h10;
    g_n = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if ((gnt0 || gnt1) && g_n < 4) begin
        g_id[g_n] = gnt1 ? 1 : 0;
        g_cyc[g_n] = c;
        push_exp(g_id[g_n], 1'b0, gnt1 ? 31'h10 : 31'h8, 32'd0, wen_unused);
        g_n++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("cont_gnt_count", 32'(g_n), 32'd4);
    for (int i = 0; i < g_n; i++) begin
      chk("cont_gnt_order", 32'(g_id[i]), 32'(i % 2));
      if (i > 0) chk("cont_gnt_gap", 32'(g_cyc[i] - g_cyc[i - 1]), 32'd2);
    end
    repeat (2) @(negedge clk);

    // Reset during the BUSY cycle of a write to byte 0x40
    w0 = wr_cnt;
    req1 = 1'b1; we1 = 1'b1; addr1 = 31'h20; wdata1 = 32'hCAFE_F00D;
    @(negedge clk);
    chk("abort_gnt1", 32'(gnt1), 32'd1);
    chk("abort_wr_en_before", 32'(mem_wr_en), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_wr_en_drop", 32'(mem_wr_en), 32'd0);
    chk("abort_gnt_drop", 32'(gnt1), 32'd0);
    chk("abort_busy_drop", 32'(busy), 32'd0);
    req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_mem_unchanged", {mem[64], mem[65], mem[66], mem[67]}, 32'h0102_0304);
    chk("abort_no_valid", 32'(q1.size()), 32'd0);

    // First tie after reset goes to requester 0
    req0 = 1'b1; we0 = 1'b0; addr0 = 31'h20;
    req1 = 1'b1; we1 = 1'b0; addr1 = 31'h8;
    @(negedge clk);
    chk("tie_after_reset_gnt0", 32'({gnt0, gnt1}), 32'b10);
    if (gnt0) push_exp(0, 1'b0, 31'h20, 32'd0, wen_unused);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(negedge clk);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
